// File: rtl/uart_port_ctrl.sv
// uart_port_ctrl: MEM-side UART access sequencer on the shared Ram1 data bus.
// Ports: wr/rd/st requests in; rdata/done/busy out; bus own/oe/data; UART flags in; wrn/rdn out.
module uart_port_ctrl #(
  parameter int SETUP_CYCLES = 1,
  parameter int PULSE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_req_i,
  input  logic        rd_req_i,
  input  logic        st_req_i,
  input  logic [15:0] wdata_i,
  output logic [15:0] rdata_o,
  output logic        done_o,
  output logic        busy_o,
  output logic        bus_own_o,
  output logic        bus_oe_o,
  output logic [7:0]  bus_data_o,
  input  logic [7:0]  bus_data_i,
  input  logic        data_ready_i,
  input  logic        tbre_i,
  input  logic        tsre_i,
  output logic        wrn,
  output logic        rdn
);

  localparam int MAXC = (SETUP_CYCLES > PULSE_CYCLES)
                      ? SETUP_CYCLES : PULSE_CYCLES;
  localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE, WR_SETUP, WR_PULSE, WR_HOLD, WAIT_TBRE,
    WAIT_TSRE, RD_WAIT, RD_PULSE, DONE
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      data_q, data_d;
  logic [15:0]     rdata_q, rdata_d;
  logic            own_q, own_d;
  logic            oe_q, oe_d;
  logic            wrn_q, wrn_d;
  logic            rdn_q, rdn_d;
  logic            done_q, done_d;
  logic            dr_m_q, tbre_m_q, tsre_m_q;
  logic            dr_s, tbre_s, tsre_s;
  logic            unused_hi;

  // Only the low byte goes out on the UART.
  assign unused_hi = ^wdata_i[15:8];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dr_m_q   <= 1'b0;
      tbre_m_q <= 1'b0;
      tsre_m_q <= 1'b0;
      dr_s     <= 1'b0;
      tbre_s   <= 1'b0;
      tsre_s   <= 1'b0;
    end else begin
      dr_m_q   <= data_ready_i;
      tbre_m_q <= tbre_i;
      tsre_m_q <= tsre_i;
      dr_s     <= dr_m_q;
      tbre_s   <= tbre_m_q;
      tsre_s   <= tsre_m_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (wr_req_i) begin
          state_d = WR_SETUP;
          cnt_d   = SETUP_LD;
          data_d  = wdata_i[7:0];
        end else if (rd_req_i) begin
          state_d = RD_WAIT;
        end else if (st_req_i) begin
          state_d = DONE;
          rdata_d = {14'b0, dr_s, tbre_s & tsre_s};
        end
      end
      WR_SETUP: begin
        if (cnt_q == '0) begin
          state_d = WR_PULSE;
          cnt_d   = PULSE_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WR_PULSE: begin
        if (cnt_q == '0) state_d = WR_HOLD;
        else             cnt_d   = cnt_q - 1'b1;
      end
      WR_HOLD:   state_d = WAIT_TBRE;
      WAIT_TBRE: if (tbre_s) state_d = WAIT_TSRE;
      WAIT_TSRE: if (tsre_s) state_d = DONE;
      RD_WAIT: begin
        if (dr_s) begin
          state_d = RD_PULSE;
          cnt_d   = PULSE_LD;
        end
      end
      RD_PULSE: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          rdata_d = {8'h00, bus_data_i};
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes and bus controls are decoded from the next state and
  // registered, so they change cleanly on the clock edge.
  always_comb begin
    own_d  = state_d inside {WR_SETUP, WR_PULSE, WR_HOLD, RD_PULSE};
    oe_d   = state_d inside {WR_SETUP, WR_PULSE, WR_HOLD};
    wrn_d  = state_d != WR_PULSE;
    rdn_d  = state_d != RD_PULSE;
    done_d = state_d == DONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      own_q   <= 1'b0;
      oe_q    <= 1'b0;
      wrn_q   <= 1'b1;
      rdn_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
      own_q   <= own_d;
      oe_q    <= oe_d;
      wrn_q   <= wrn_d;
      rdn_q   <= rdn_d;
      done_q  <= done_d;
    end
  end

  assign busy_o = (state_q == IDLE) ? (wr_req_i | rd_req_i)
                                    : (state_q != DONE);
  assign rdata_o    = rdata_q;
  assign done_o     = done_q;
  assign bus_own_o  = own_q;
  assign bus_oe_o   = oe_q;
  assign bus_data_o = data_q;
  assign wrn        = wrn_q;
  assign rdn        = rdn_q;

endmodule

// File: tb/tb_uart_port_ctrl.sv
// tb_uart_port_ctrl: randomized bench for uart_port_ctrl.
// Transaction-level model predicts latency, strobe widths and rdata.
module tb_uart_port_ctrl;

  localparam int S = 1;
  localparam int P = 2;
  localparam int NO = -100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_req_i = 1'b0;
  logic        rd_req_i = 1'b0;
  logic        st_req_i = 1'b0;
  logic [15:0] wdata_i = '0;
  logic [15:0] rdata_o;
  logic        done_o;
  logic        busy_o;
  logic        bus_own_o;
  logic        bus_oe_o;
  logic [7:0]  bus_data_o;
  logic [7:0]  bus_data_i = '0;
  logic        data_ready_i = 1'b0;
  logic        tbre_i = 1'b0;
  logic        tsre_i = 1'b0;
  logic        wrn;
  logic        rdn;

  int n_chk = 0;
  int n_pass = 0;
  logic [15:0] m_rdata = '0;

  uart_port_ctrl #(.SETUP_CYCLES(S), .PULSE_CYCLES(P)) dut (
    .clk(clk), .rst(rst),
    .wr_req_i(wr_req_i), .rd_req_i(rd_req_i), .st_req_i(st_req_i),
    .wdata_i(wdata_i), .rdata_o(rdata_o), .done_o(done_o),
    .busy_o(busy_o), .bus_own_o(bus_own_o), .bus_oe_o(bus_oe_o),
    .bus_data_o(bus_data_o), .bus_data_i(bus_data_i),
    .data_ready_i(data_ready_i), .tbre_i(tbre_i), .tsre_i(tsre_i),
    .wrn(wrn), .rdn(rdn)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bus ownership rules, every cycle.
  always @(negedge clk) begin
    chk("inv",
        int'((wrn & rdn | bus_own_o) & (wrn | rdn) & (~bus_oe_o | bus_own_o)),
        1);
  end

  task automatic prep(input bit tb, input bit ts, input bit dr);
    tbre_i = tb;
    tsre_i = ts;
    data_ready_i = dr;
    repeat (3) @(negedge clk);
  endtask

  // Called at a negedge in IDLE; flag times are relative to the cycle
  // after the accept edge (NO = flag left as prepared).
  task automatic xfer(input bit w, input bit r, input bit s,
                      input logic [15:0] d, input int ttb, input int tts,
                      input int tdr, input logic [7:0] bd, input bit keep_rd);
    int kexp, e1, kd, nwrn, nrdn, noe, fwrn, frdn, foe, badbusy;
    bit got;
    logic [15:0] exp_rd;
    e1 = 0;
    if (w) begin
      e1 = imax(S + P + 2, ttb + 3);
      kexp = imax(e1 + 1, tts + 3);
      exp_rd = m_rdata;
    end else if (r) begin
      e1 = imax(1, tdr + 3);
      kexp = e1 + P;
      exp_rd = {8'h00, bd};
    end else begin
      kexp = 0;
      exp_rd = {14'b0, data_ready_i, tbre_i & tsre_i};
    end
    bus_data_i = bd;
    wdata_i = d;
    wr_req_i = w;
    rd_req_i = r;
    st_req_i = s;
    #1 chk("busy_req", int'(busy_o), int'(w | r));
    got = 0; kd = -1;
    nwrn = 0; nrdn = 0; noe = 0;
    fwrn = -1; frdn = -1; foe = -1; badbusy = 0;
    for (int k = 0; k < 400 && !got; k++) begin
      @(negedge clk);
      if (k == ttb) tbre_i = 1'b1;
      if (k == tts) tsre_i = 1'b1;
      if (k == tdr) data_ready_i = 1'b1;
      if (!wrn) begin if (fwrn < 0) fwrn = k; nwrn++; end
      if (!rdn) begin if (frdn < 0) frdn = k; nrdn++; end
      if (bus_oe_o) begin if (foe < 0) foe = k; noe++; end
      if (k == 0 && w) chk("wr_data", int'(bus_data_o), int'(d[7:0]));
      if (busy_o != (done_o ? 1'b0 : (w | r))) badbusy++;
      if (done_o) begin got = 1; kd = k; end
    end
    chk("timeout", int'(got), 1);
    chk("done_k", kd, kexp);
    if (w) begin
      chk("wrn_first", fwrn, S);
      chk("wrn_len", nwrn, P);
      chk("oe_first", foe, 0);
      chk("oe_len", noe, S + P + 1);
    end else begin
      chk("wrn_len", nwrn, 0);
      chk("oe_len", noe, 0);
    end
    if (r && !w) begin
      chk("rdn_first", frdn, e1);
      chk("rdn_len", nrdn, P);
    end else begin
      chk("rdn_len", nrdn, 0);
    end
    chk("busy", badbusy, 0);
    chk("rdata", int'(rdata_o), int'(exp_rd));
    m_rdata = exp_rd;
    wr_req_i = 1'b0;
    st_req_i = 1'b0;
    rd_req_i = keep_rd;
    @(negedge clk);
    chk("done_w", int'(done_o), 0);
  endtask

  function automatic int rnd_t();
    return ($urandom_range(0, 1) == 0) ? NO : int'($urandom_range(0, 15));
  endfunction

  initial begin
    int ttb, tts, tdr;
    bit xr, xs;
    repeat (2) @(negedge clk);
    chk("rst_wrn", int'(wrn), 1);
    chk("rst_rdn", int'(rdn), 1);
    chk("rst_oe", int'(bus_oe_o), 0);
    chk("rst_own", int'(bus_own_o), 0);
    chk("rst_data", int'(bus_data_o), 0);
    chk("rst_rdata", int'(rdata_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    rst = 1'b1;
    @(negedge clk);

    // Fast write, then slow transmitter.
    prep(1, 1, 0);
    xfer(1, 0, 0, 16'h1241, NO, NO, NO, 8'h00, 0);
    prep(0, 0, 0);
    xfer(1, 0, 0, 16'h77E3, S + P + 21, S + P + 26, NO, 8'h00, 0);
    // Read with late data_ready, then status.
    prep(1, 1, 0);
    xfer(0, 1, 0, 16'h0000, NO, NO, 10, 8'h5A, 0);
    prep(1, 0, 1);
    xfer(0, 0, 1, 16'h0000, NO, NO, NO, 8'h00, 0);
    // All three together: write wins, held read follows.
    prep(1, 1, 1);
    xfer(1, 1, 1, 16'hBE96, NO, NO, NO, 8'h00, 1);
    xfer(0, 1, 0, 16'h0000, NO, NO, NO, 8'hC3, 0);

    // Reset in the middle of the write pulse.
    prep(1, 1, 0);
    wdata_i = 16'hABCD;
    wr_req_i = 1'b1;
    repeat (S + 1) @(negedge clk);
    chk("rp_wrn_low", int'(wrn), 0);
    #2 rst = 1'b0;
    wr_req_i = 1'b0;
    #1;
    chk("rp_wrn", int'(wrn), 1);
    chk("rp_rdn", int'(rdn), 1);
    chk("rp_oe", int'(bus_oe_o), 0);
    chk("rp_own", int'(bus_own_o), 0);
    chk("rp_busy", int'(busy_o), 0);
    repeat (2) begin
      @(negedge clk);
      chk("rp_done", int'(done_o), 0);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rp_rdata", int'(rdata_o), 0);
    chk("rp_busy2", int'(busy_o), 0);
    chk("rp_done2", int'(done_o), 0);
    m_rdata = '0;
    prep(0, 1, 1);
    xfer(0, 0, 1, 16'h0000, NO, NO, NO, 8'h00, 0);

    for (int i = 0; i < 40; i++) begin
      xr = 1'($urandom_range(0, 1));
      xs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0: begin
          ttb = rnd_t();
          tts = rnd_t();
          prep(ttb < 0, tts < 0, 1'($urandom_range(0, 1)));
          xfer(1, xr, xs, 16'($urandom), ttb, tts, NO, 8'h00, 0);
        end
        1: begin
          tdr = rnd_t();
          prep(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), tdr < 0);
          xfer(0, 1, xs, 16'h0000, NO, NO, tdr, 8'($urandom), 0);
        end
        default: begin
          prep(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
          xfer(0, 0, 1, 16'h0000, NO, NO, NO, 8'h00, 0);
        end
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_port_ctrl.md
Name: uart_port_ctrl

Overview:
- Serial-port access controller driven by the MEM stage.
- Turns single-cycle read, write and status requests from MEM into the on-board UART handshake (wrn/rdn strobes, data_ready/tbre/tsre flags) on the data bus it shares with Ram1.
- Raises a stall to the hazard path while an access is in flight.
- Tells MEM when it owns the Ram1 data bus, so Ram1 can be disabled during that time.

Parameters:
- SETUP_CYCLES, 1: cycles write data is driven before wrn falls (min 1).
- PULSE_CYCLES, 2: low width of wrn/rdn strobes in clk cycles (min 1).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- wr_req_i  in  1  write request (byte = wdata_i[7:0]); held by MEM while busy_o=1
- rd_req_i  in  1  read data request (port 0xBF00); held while busy_o=1
- st_req_i  in  1  status read request (port 0xBF01)
- wdata_i  in  16  write data from MEM
- rdata_o  out  16  result of the last read/status access
- done_o  out  1  one-cycle pulse: access complete, rdata_o valid
- busy_o  out  1  stall request to hazard unit
- bus_own_o  out  1  controller owns the Ram1 data bus; MEM forces Ram1EN=1, Ram1OE=1, Ram1WE=1
- bus_oe_o  out  1  drive enable for bus_data_o onto Ram1Data[7:0]
- bus_data_o  out  8  byte to transmit
- bus_data_i  in  8  Ram1Data[7:0] as seen at the pad
- data_ready_i  in  1  UART receive byte available (async)
- tbre_i  in  1  UART transmit buffer empty (async)
- tsre_i  in  1  UART transmit shift register empty (async)
- wrn  out  1  UART write strobe, active low
- rdn  out  1  UART read strobe, active low

Behaviour:
- Reset (rst=0, asynchronous, effective immediately, including mid-access):
  - state=IDLE, wrn=1, rdn=1, bus_oe_o=0, bus_own_o=0, bus_data_o=0, rdata_o=0, done_o=0, busy_o=0.
  - Synchronisers are cleared to 0. The access in progress is abandoned; no done_o.
- Input synchronisation:
  - data_ready_i, tbre_i and tsre_i each pass through 2 flops (dr_s, tbre_s, tsre_s).
  - All decisions use the synchronised copies, so there are 2 cycles of flag latency.
- Acceptance:
  - Requests are sampled only in IDLE.
  - Priority when several are asserted together: wr > rd > st.
  - Requests in any other state are ignored.
- busy_o:
  - Combinational.
  - 1 in IDLE when wr_req_i or rd_req_i is asserted.
  - 1 in every state except IDLE and DONE.
  - 0 for st_req_i.
- States: IDLE, WR_SETUP, WR_PULSE, WR_HOLD, WAIT_TBRE, WAIT_TSRE, RD_WAIT, RD_PULSE, DONE.
- Write path:
  - On the accept edge, latch bus_data_o=wdata_i[7:0] (upper byte dropped) and go to WR_SETUP.
  - WR_SETUP: SETUP_CYCLES cycles; own=1, oe=1, wrn=1.
  - WR_PULSE: PULSE_CYCLES cycles; own=1, oe=1, wrn=0.
  - WR_HOLD: 1 cycle; own=1, oe=1, wrn=1 (data hold after rising edge).
  - WAIT_TBRE: own=0, oe=0; leave when tbre_s=1.
  - WAIT_TSRE: leave when tsre_s=1, then go to DONE.
  - Flags already high move the FSM through each wait state in 1 cycle each.
- Read path:
  - RD_WAIT: own=0, rdn=1; wait until dr_s=1. The wait is unbounded (software must poll status first).
  - RD_PULSE: PULSE_CYCLES cycles; own=1, oe=0, rdn=0.
  - On the edge ending the last RD_PULSE cycle, rdata_o={8'h00, bus_data_i} and rdn returns to 1 with the transition to DONE.
- Status path:
  - On the accept edge, rdata_o={14'b0, dr_s, tbre_s & tsre_s}; bit1 = data ready, bit0 = transmitter idle.
  - Go directly to DONE. Total latency 1 cycle, no stall.
- DONE:
  - Exactly 1 cycle: done_o=1, busy_o=0, own=0, strobes high.
  - Always returns to IDLE; a request present in DONE is not accepted until IDLE.
- Ownership invariants:
  - wrn=0 or rdn=0 implies bus_own_o=1.
  - wrn and rdn are never low together.
  - bus_oe_o=1 only in WR_SETUP, WR_PULSE and WR_HOLD.
- Counters:
  - A single down-counter sized for max(SETUP_CYCLES, PULSE_CYCLES).
  - Loaded on entry to each timed state; exit when it reaches 0.
- rdata_o holds its value until the next read or status completion; writes do not alter it.

Test Plan:
- Write: tbre/tsre=1, wr_req with wdata=16'h1241 -> bus_data_o=8'h41, oe high for 4 cycles, wrn low for exactly 2 cycles (starting after 1 setup cycle); done_o pulses 1 cycle after the WAIT states (total 7 cycles accept→done); busy_o=1 throughout except in DONE.
- Slow transmitter: tbre held 0 for 20 cycles after WR_HOLD, tsre rises 5 cycles after tbre -> FSM stays in WAIT_TBRE/WAIT_TSRE accordingly; done_o fires 2 sync cycles after the last flag edge; oe=0 during the waits.
- Read: rd_req with data_ready=0, raise data_ready 10 cycles later with bus_data_i=8'h5A -> rdn low for 2 cycles after the sync delay; rdata_o=16'h005A and done_o=1 in the next cycle.
- Status: data_ready=1, tbre=1, tsre=0 (held ≥3 cycles), st_req -> rdata_o=16'h0002, done_o next cycle, busy_o never asserted.
- Simultaneous wr_req+rd_req+st_req -> write performed; rd/st ignored until DONE; re-held rd_req is accepted in the following IDLE.
- rst pulled low during WR_PULSE -> wrn, rdn, bus_oe_o and bus_own_o go to inactive immediately without waiting for clk; no done_o; after release, state=IDLE and rdata_o=0.
